// File: rtl/tod_pkg.sv
// Shared constants and types for the time-of-day counter slice.
package tod_pkg;

    localparam int unsigned SEC_PER_MIN = 60;
    localparam int unsigned MIN_PER_HR  = 60;

    // hr is a fixed 5-bit field, wide enough for both 12- and 24-hour days
    localparam int unsigned HR_W = 5;

    typedef enum logic [1:0] {
        FIELD_HR   = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_SEC  = 2'd2,
        FIELD_NONE = 2'd3
    } field_e;

endpackage

// File: rtl/tod_counter_if.sv
// Control, alarm and time-field bundle between the tick source side and tod_counter.
interface tod_counter_if #(
    parameter int unsigned TICK_W = 14
);

    logic              enable;
    logic              set_en;
    logic [1:0]        set_sel;
    logic              inc_btn;
    logic              dec_btn;
    logic              alarm_en;
    logic [4:0]        alarm_hr;
    logic [5:0]        alarm_min;
    logic [TICK_W-1:0] tick_cnt;
    logic [5:0]        sec;
    logic [5:0]        min;
    logic [4:0]        hr;
    logic              sec_pulse;
    logic              day_wrap;
    logic              alarm_hit;

    modport master (
        output enable, set_en, set_sel, inc_btn, dec_btn, alarm_en, alarm_hr, alarm_min,
        input  tick_cnt, sec, min, hr, sec_pulse, day_wrap, alarm_hit
    );

    modport slave (
        input  enable, set_en, set_sel, inc_btn, dec_btn, alarm_en, alarm_hr, alarm_min,
        output tick_cnt, sec, min, hr, sec_pulse, day_wrap, alarm_hit
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up/down counter with synchronous clear; wrap_up flags an increment out of MOD-1
// combinationally so the parent can chain carries on the same edge.
module mod_counter #(
    parameter int unsigned MOD = 60,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         wrap_up
);

    localparam logic [W-1:0] Max = W'(MOD - 1);

    logic [W-1:0] value_q, value_d;

    // Simultaneous inc and dec cancel out; clr wins over both.
    always_comb begin
        value_d = value_q;
        wrap_up = 1'b0;
        if (clr) begin
            value_d = '0;
        end else if (inc && !dec) begin
            if (value_q == Max) begin
                value_d = '0;
                wrap_up = 1'b1;
            end else begin
                value_d = value_q + 1'b1;
            end
        end else if (dec && !inc) begin
            value_d = (value_q == '0) ? Max : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: tick divider, sec/min/hr carry chain, button-driven field setting
// and an hour:minute alarm. All outputs registered, fields update on the final-tick edge.
module tod_counter
    import tod_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 10000,
    parameter int unsigned HOURS_PER_DAY = 24,
    parameter int unsigned TICK_W        = $clog2(TICK_DIV)
) (
    input logic          clk,
    input logic          reset,
    tod_counter_if.slave bus
);

    localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic              inc_prev_q, dec_prev_q;
    logic              sec_pulse_q, day_wrap_q, alarm_hit_q;

    logic [5:0]        sec_val, min_val;
    logic [HR_W-1:0]   hr_val;
    logic              sec_wrap, min_wrap, hr_wrap;

    field_e            sel;
    logic              tick_last, sec_tick;
    logic              inc_edge, dec_edge, adj_up, adj_dn;
    logic              sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
    logic [5:0]        next_min;
    logic [HR_W-1:0]   next_hr;
    logic              alarm_match, day_wrap_d;

    always_comb begin
        sel       = field_e'(bus.set_sel);
        tick_last = (tick_q == TickLast);
        sec_tick  = !bus.set_en && bus.enable && tick_last;

        inc_edge  = bus.inc_btn && !inc_prev_q;
        dec_edge  = bus.dec_btn && !dec_prev_q;
        adj_up    = bus.set_en && inc_edge && !dec_edge;
        adj_dn    = bus.set_en && dec_edge && !inc_edge;

        // Carries only propagate while counting; manual adjustments stay within their field.
        sec_inc   = sec_tick || (adj_up && sel == FIELD_SEC);
        sec_dec   = adj_dn && sel == FIELD_SEC;
        min_inc   = (sec_wrap && !bus.set_en) || (adj_up && sel == FIELD_MIN);
        min_dec   = adj_dn && sel == FIELD_MIN;
        hr_inc    = (min_wrap && !bus.set_en) || (adj_up && sel == FIELD_HR);
        hr_dec    = adj_dn && sel == FIELD_HR;

        if (bus.set_en) begin
            tick_d = '0;
        end else if (bus.enable) begin
            tick_d = tick_last ? '0 : tick_q + 1'b1;
        end else begin
            tick_d = tick_q;
        end

        // {hr,min} as they will read after this edge's minute carry.
        next_min = min_wrap ? 6'd0 : min_val + 6'd1;
        if (hr_wrap) begin
            next_hr = '0;
        end else if (min_wrap) begin
            next_hr = hr_val + 1'b1;
        end else begin
            next_hr = hr_val;
        end

        // next_* are always in range, so out-of-range alarm settings can never compare equal.
        alarm_match = sec_wrap && !bus.set_en && bus.alarm_en &&
                      next_min == bus.alarm_min && next_hr == bus.alarm_hr;
        day_wrap_d  = hr_wrap && !bus.set_en;
    end

    mod_counter #(
        .MOD (SEC_PER_MIN),
        .W   (6)
    ) u_sec (
        .clk     (clk),
        .clr     (reset),
        .inc     (sec_inc),
        .dec     (sec_dec),
        .value   (sec_val),
        .wrap_up (sec_wrap)
    );

    mod_counter #(
        .MOD (MIN_PER_HR),
        .W   (6)
    ) u_min (
        .clk     (clk),
        .clr     (reset),
        .inc     (min_inc),
        .dec     (min_dec),
        .value   (min_val),
        .wrap_up (min_wrap)
    );

    mod_counter #(
        .MOD (HOURS_PER_DAY),
        .W   (HR_W)
    ) u_hr (
        .clk     (clk),
        .clr     (reset),
        .inc     (hr_inc),
        .dec     (hr_dec),
        .value   (hr_val),
        .wrap_up (hr_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q      <= '0;
            inc_prev_q  <= 1'b0;
            dec_prev_q  <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            inc_prev_q  <= bus.inc_btn;
            dec_prev_q  <= bus.dec_btn;
            sec_pulse_q <= sec_tick;
            day_wrap_q  <= day_wrap_d;
            alarm_hit_q <= alarm_match;
        end
    end

    assign bus.tick_cnt  = tick_q;
    assign bus.sec       = sec_val;
    assign bus.min       = min_val;
    assign bus.hr        = hr_val;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_wrap  = day_wrap_q;
    assign bus.alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter: 24h and 12h instances driven alike, checked every cycle against a
// seconds-of-day reference model.
module tb_tod_counter;

    localparam int unsigned TickDiv = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable, set_en, inc_btn, dec_btn, alarm_en;
    logic [1:0] set_sel;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;

    always #5 clk = ~clk;

    tod_counter_if #(.TICK_W(2)) bus24 ();
    tod_counter_if #(.TICK_W(2)) bus12 ();

    assign bus24.enable    = enable;
    assign bus24.set_en    = set_en;
    assign bus24.set_sel   = set_sel;
    assign bus24.inc_btn   = inc_btn;
    assign bus24.dec_btn   = dec_btn;
    assign bus24.alarm_en  = alarm_en;
    assign bus24.alarm_hr  = alarm_hr;
    assign bus24.alarm_min = alarm_min;
    assign bus12.enable    = enable;
    assign bus12.set_en    = set_en;
    assign bus12.set_sel   = set_sel;
    assign bus12.inc_btn   = inc_btn;
    assign bus12.dec_btn   = dec_btn;
    assign bus12.alarm_en  = alarm_en;
    assign bus12.alarm_hr  = alarm_hr;
    assign bus12.alarm_min = alarm_min;

    tod_counter #(
        .TICK_DIV      (TickDiv),
        .HOURS_PER_DAY (24),
        .TICK_W        (2)
    ) dut24 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus24.slave)
    );

    tod_counter #(
        .TICK_DIV      (TickDiv),
        .HOURS_PER_DAY (12),
        .TICK_W        (2)
    ) dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: index 0 is the 24h instance, index 1 the 12h one.
    int m_tick [2];
    int m_t    [2];
    int m_sp   [2];
    int m_dw   [2];
    int m_ah   [2];
    int m_hpd  [2] = '{24, 12};
    int m_incp = 0;
    int m_decp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_one(input int i, input bit ie, input bit de);
        int h, m, s, d, day;
        m_sp[i] = 0;
        m_dw[i] = 0;
        m_ah[i] = 0;
        day     = m_hpd[i] * 3600;
        if (reset) begin
            m_tick[i] = 0;
            m_t[i]    = 0;
        end else if (set_en) begin
            m_tick[i] = 0;
            if (ie != de && set_sel != 2'd3) begin
                h = m_t[i] / 3600;
                m = (m_t[i] / 60) % 60;
                s = m_t[i] % 60;
                d = ie ? 1 : -1;
                case (set_sel)
                    2'd0:    h = (h + d + m_hpd[i]) % m_hpd[i];
                    2'd1:    m = (m + d + 60) % 60;
                    default: s = (s + d + 60) % 60;
                endcase
                m_t[i] = h * 3600 + m * 60 + s;
            end
        end else if (enable) begin
            if (m_tick[i] == TickDiv - 1) begin
                m_tick[i] = 0;
                m_t[i]    = (m_t[i] + 1) % day;
                m_sp[i]   = 1;
                m_dw[i]   = (m_t[i] == 0) ? 1 : 0;
                if (alarm_en && m_t[i] % 60 == 0 && alarm_hr < m_hpd[i] && alarm_min < 60 &&
                    m_t[i] / 60 == int'(alarm_hr) * 60 + int'(alarm_min))
                    m_ah[i] = 1;
            end else begin
                m_tick[i]++;
            end
        end
    endtask

    task automatic cycle();
        bit ie, de;
        ie = inc_btn && (m_incp == 0);
        de = dec_btn && (m_decp == 0);
        for (int i = 0; i < 2; i++) model_one(i, ie, de);
        m_incp = reset ? 0 : int'(inc_btn);
        m_decp = reset ? 0 : int'(dec_btn);
        @(posedge clk);
        #1;
        check("tick24", 32'(bus24.tick_cnt), m_tick[0]);
        check("sec24", 32'(bus24.sec), m_t[0] % 60);
        check("min24", 32'(bus24.min), (m_t[0] / 60) % 60);
        check("hr24", 32'(bus24.hr), m_t[0] / 3600);
        check("sec_pulse24", 32'(bus24.sec_pulse), m_sp[0]);
        check("day_wrap24", 32'(bus24.day_wrap), m_dw[0]);
        check("alarm_hit24", 32'(bus24.alarm_hit), m_ah[0]);
        check("tick12", 32'(bus12.tick_cnt), m_tick[1]);
        check("sec12", 32'(bus12.sec), m_t[1] % 60);
        check("min12", 32'(bus12.min), (m_t[1] / 60) % 60);
        check("hr12", 32'(bus12.hr), m_t[1] / 3600);
        check("sec_pulse12", 32'(bus12.sec_pulse), m_sp[1]);
        check("day_wrap12", 32'(bus12.day_wrap), m_dw[1]);
        check("alarm_hit12", 32'(bus12.alarm_hit), m_ah[1]);
    endtask

    task automatic press(input bit up);
        if (up) inc_btn = 1'b1;
        else    dec_btn = 1'b1;
        cycle();
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        cycle();
    endtask

    // Enters set mode from reset and dials in HH:59:59 with HH = hrs presses of inc.
    task automatic preload_xx5959(input int hrs);
        reset = 1'b1;
        cycle();
        reset  = 1'b0;
        set_en = 1'b1;
        set_sel = 2'd0;
        if (hrs == 0) press(1'b0);
        for (int k = 0; k < hrs; k++) press(1'b1);
        set_sel = 2'd1;
        press(1'b0);
        set_sel = 2'd2;
        press(1'b0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; set_en = 1'b0; set_sel = 2'd3;
        inc_btn = 1'b0; dec_btn = 1'b0; alarm_en = 1'b0; alarm_hr = '0; alarm_min = '0;
        repeat (2) cycle();
        reset  = 1'b0;
        enable = 1'b1;
        repeat (30) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;

        // 23:59:59 (11:59:59 on the 12h instance), then a full-chain wrap
        preload_xx5959(0);
        check("preload_hr24", 32'(bus24.hr), 23);
        check("preload_hr12", 32'(bus12.hr), 11);
        set_en = 1'b0;
        repeat (4) cycle();
        check("wrap_hms24", {bus24.hr, bus24.min, bus24.sec}, 0);
        check("wrap_dw12", 32'(bus12.day_wrap), 1);
        cycle();

        // held inc gives one step, simultaneous edges cancel
        set_en = 1'b1; set_sel = 2'd0;
        inc_btn = 1'b1;
        repeat (10) cycle();
        inc_btn = 1'b0;
        cycle();
        check("held_inc_hr24", 32'(bus24.hr), 1);
        inc_btn = 1'b1; dec_btn = 1'b1;
        cycle();
        inc_btn = 1'b0; dec_btn = 1'b0;
        cycle();
        check("both_edges_hr24", 32'(bus24.hr), 1);
        set_sel = 2'd1;
        press(1'b0);
        press(1'b1);
        check("min_wrap_nocarry_hr24", 32'(bus24.hr), 1);
        set_en = 1'b0;
        repeat (4) cycle();
        check("first_sec_pulse24", 32'(bus24.sec_pulse), 1);

        // enable dropped mid-second
        repeat (2) cycle();
        enable = 1'b0;
        repeat (7) cycle();
        enable = 1'b1;
        repeat (10) cycle();

        // alarm at 07:00 from a running clock
        alarm_hr = 5'd7; alarm_min = 6'd0; alarm_en = 1'b1;
        preload_xx5959(6);
        set_en = 1'b0;
        repeat (4) cycle();
        check("alarm_run24", 32'(bus24.alarm_hit), 1);
        repeat (3) cycle();

        // 07:00:00 reached by manual setting, then alarm disarmed across 07:01:00
        preload_xx5959(6);
        set_sel = 2'd0; press(1'b1);
        set_sel = 2'd1; press(1'b1);
        set_sel = 2'd2; press(1'b1);
        alarm_en = 1'b0; alarm_min = 6'd1;
        set_en = 1'b0;
        repeat (250) cycle();

        // randomized phase
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(199) == 0);
            if ($urandom_range(39) == 0) set_en = ~set_en;
            enable = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) inc_btn = ~inc_btn;
            if ($urandom_range(3) == 0) dec_btn = ~dec_btn;
            if ($urandom_range(7) == 0) set_sel = 2'($urandom_range(3));
            if ($urandom_range(49) == 0) begin
                alarm_en = ($urandom_range(3) != 0);
                if ($urandom_range(1) == 0) begin
                    alarm_min = 6'(((m_t[0] / 60) + 1) % 60);
                    alarm_hr  = 5'(m_t[0] / 3600);
                end else begin
                    alarm_min = 6'($urandom_range(63));
                    alarm_hr  = 5'($urandom_range(31));
                end
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
